dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port Data_Memory between the pipeline MEM stage (CPU) and a debug/loader port (DBG).
//  Arbitrates per cycle with CPU priority plus a starvation bound for DBG; drives the Data_Memory bus
//  (mem_read/mem_write/opcode/func3/addr/dataW) from registers; returns load data to the winner with a pulsed valid.
// PARAMETERS
//  ADDR_W      32  address width, all ports
//  DATA_W      32  data width, all ports
//  STARVE_MAX  4   max consecutive CPU grants while dbg_req is held before DBG is forced to win (>=1)
// PORTS
//  clk         in   1       clock, all state on posedge
//  rst         in   1       asynchronous reset, active-high
//  cpu_req     in   1       CPU access request; held (with fields stable) until cpu_gnt
//  cpu_we      in   1       1=store, 0=load
//  cpu_opcode  in   7       forwarded to opcode (7'd3 load, 7'd35 store)
//  cpu_func3   in   3       width/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  cpu_addr    in   ADDR_W  byte address
//  cpu_wdata   in   DATA_W  store data
//  cpu_gnt     out  1       comb: request accepted this cycle
//  cpu_stall   out  1       comb: cpu_req & ~cpu_gnt
//  cpu_rdata   out  DATA_W  load result, valid with cpu_rvalid
//  cpu_rvalid  out  1       1-cycle pulse per accepted CPU load
//  dbg_req/dbg_we/dbg_func3/dbg_addr/dbg_wdata  in  1/1/3/ADDR_W/DATA_W  as CPU; opcode generated internally
//  dbg_gnt     out  1       comb accept
//  dbg_rdata   out  DATA_W  load result
//  dbg_rvalid  out  1       1-cycle pulse per accepted DBG load
//  mem_read, mem_write  out 1       Data_Memory strobes (registered)
//  opcode      out  7       registered; DBG: 7'd3 load / 7'd35 store
//  func3       out  3       registered
//  addr        out  ADDR_W  registered
//  dataW       out  DATA_W  registered
//  dataR       in   DATA_W  Data_Memory read data (combinational from addr)
// BEHAVIOUR
//  Reset: all outputs, bus registers, rdata/rvalid, starve_cnt, owner and lock state = 0; applies mid-access (strobes drop at once).
//  Grant (comb, every cycle): only cpu_req -> CPU; only dbg_req -> DBG; both -> DBG iff starve_cnt==STARVE_MAX, else CPU.
//  starve_cnt: +1 on CPU grant while dbg_req=1 (saturates); cleared on DBG grant or when dbg_req=0.
//  Pipeline: accept in cycle N -> bus registers loaded at edge ending N -> strobes/fields driven in N+1 ->
//   loads: dataR captured at edge ending N+1 into winner's rdata, rvalid=1 in N+2 only; stores: written at edge ending N+1, no rvalid.
//  Throughput one access/cycle; no grant -> mem_read=mem_write=0 next cycle (fields hold last value).
//  Owner tag registered with bus; routes capture to the correct port. rdata holds until next own load.
//  Order preserved: store accepted N then load accepted N+1 (any port, same addr) returns new data.
//  Simultaneous cpu_rvalid and dbg_rvalid impossible (one access per cycle).
// CONFIGURATION
//  DMEM_ARB_LOCK_EN defined: adds input dbg_lock (1). While dbg_lock=1 CPU is never granted (cpu_stall=cpu_req),
//   DBG granted whenever dbg_req; starve_cnt held at 0. Deassert returns to normal arbitration next cycle.
//  Undefined: no dbg_lock port; arbitration as above only.
// TESTING
//  Reset: rst=1 with random inputs -> all outputs 0; release -> no strobe until a request.
//  CPU LB: memory word0=32'h8433_2211, cpu_req LB addr 3 accepted N -> mem_read=1,addr=3 in N+1; cpu_rvalid in N+2, cpu_rdata=32'hFFFF_FF84.
//  Fairness, STARVE_MAX=4: cpu_req and dbg_req held high 15 cycles -> grants C,C,C,C,D,C,C,C,C,D,...; no gap cycles.
//  Cross-port coherence: DBG SW 32'hDEAD_BEEF to addr 8, next cycle CPU LW addr 8 -> cpu_rdata=32'hDEAD_BEEF, dbg_rvalid never pulses.
//  Reset mid-access: rst asserted during N+1 of a CPU SW -> mem_write=0 immediately; no cpu_rvalid; starve_cnt=0 after release.
//  DMEM_ARB_LOCK_EN: dbg_lock=1, both req 6 cycles -> six DBG grants, cpu_stall=1 throughout; dbg_lock=0 -> CPU granted next cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, DBG and Data_Memory bus signals of the data-memory arbiter
interface dmem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              cpu_req;
  logic              cpu_we;
  logic [6:0]        cpu_opcode;
  logic [2:0]        cpu_func3;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              dbg_req;
  logic              dbg_we;
  logic [2:0]        dbg_func3;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;
  logic              mem_read;
  logic              mem_write;
  logic [6:0]        opcode;
  logic [2:0]        func3;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dataW;
  logic [DATA_W-1:0] dataR;
  modport slave (
    input  cpu_req, cpu_we, cpu_opcode, cpu_func3, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_func3, dbg_addr, dbg_wdata, dataR,
    output cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output mem_read, mem_write, opcode, func3, addr, dataW
  );
  modport master (
    output cpu_req, cpu_we, cpu_opcode, cpu_func3, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_func3, dbg_addr, dbg_wdata, dataR,
    input  cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  mem_read, mem_write, opcode, func3, addr, dataW
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares Data_Memory between CPU and DBG; optional DMEM_ARB_LOCK_EN adds dbg_lock
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
`ifdef DMEM_ARB_LOCK_EN
  input logic dbg_lock,
`endif
  dmem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic              lock;
  logic              cpu_gnt, dbg_gnt;
  logic [CW-1:0]     starve_q, starve_d;
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic              owner_q, owner_d;
  logic [6:0]        opcode_q, opcode_d;
  logic [2:0]        func3_q, func3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d, dbg_rvalid_q, dbg_rvalid_d;
`ifdef DMEM_ARB_LOCK_EN
  assign lock = dbg_lock;
`else
  assign lock = 1'b0;
`endif
  // grant: CPU has priority unless DBG has waited STARVE_MAX grants or holds the lock; nothing is granted in reset
  always_comb begin
    dbg_gnt = ~rst & bus.dbg_req & (lock | ~bus.cpu_req | (starve_q == CW'(STARVE_MAX)));
    cpu_gnt = ~rst & bus.cpu_req & ~lock & ~dbg_gnt;
  end
  // next state: starvation counter, registered bus fields with owner tag, and load-data return to the owner
  always_comb begin
    starve_d     = (lock | ~bus.dbg_req | dbg_gnt) ? '0 :
                   (cpu_gnt & (starve_q != CW'(STARVE_MAX))) ? starve_q + CW'(1) : starve_q;
    mem_read_d   = (cpu_gnt & ~bus.cpu_we) | (dbg_gnt & ~bus.dbg_we);
    mem_write_d  = (cpu_gnt & bus.cpu_we) | (dbg_gnt & bus.dbg_we);
    owner_d      = dbg_gnt ? 1'b1 : cpu_gnt ? 1'b0 : owner_q;
    opcode_d     = dbg_gnt ? (bus.dbg_we ? 7'd35 : 7'd3) : cpu_gnt ? bus.cpu_opcode : opcode_q;
    func3_d      = dbg_gnt ? bus.dbg_func3 : cpu_gnt ? bus.cpu_func3 : func3_q;
    addr_d       = dbg_gnt ? bus.dbg_addr : cpu_gnt ? bus.cpu_addr : addr_q;
    wdata_d      = dbg_gnt ? bus.dbg_wdata : cpu_gnt ? bus.cpu_wdata : wdata_q;
    cpu_rvalid_d = mem_read_q & ~owner_q;
    dbg_rvalid_d = mem_read_q & owner_q;
    cpu_rdata_d  = cpu_rvalid_d ? bus.dataR : cpu_rdata_q;
    dbg_rdata_d  = dbg_rvalid_d ? bus.dataR : dbg_rdata_q;
  end
  // state registers; reset clears everything, including an access already on the bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q     <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      owner_q      <= 1'b0;
      opcode_q     <= '0;
      func3_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      starve_q     <= starve_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      owner_q      <= owner_d;
      opcode_q     <= opcode_d;
      func3_q      <= func3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end
  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.cpu_stall  = ~rst & bus.cpu_req & ~cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.opcode     = opcode_q;
  assign bus.func3      = func3_q;
  assign bus.addr       = addr_q;
  assign bus.dataW      = wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench with a Data_Memory model and a load-return scoreboard
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic g_cpu, g_dbg, g_stall;
  logic [31:0] cpu_exp, dbg_exp;
  logic [31:0] mem [0:63];
  logic [31:0] rd_word;
  typedef struct {logic dbg; logic [31:0] data; int due;} exp_t;
  exp_t sb[$];
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
`ifdef DMEM_ARB_LOCK_EN
  logic dbg_lock;
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (.clk(clk), .rst(rst), .dbg_lock(dbg_lock), .bus(bus));
`else
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Data_Memory model: combinational sized/sign-extended read, byte/half/word write on the clock edge
  always_comb begin
    rd_word = mem[bus.addr[7:2]] >> {bus.addr[1:0], 3'b000};
    case (bus.func3)
      3'd0:    bus.dataR = {{24{rd_word[7]}}, rd_word[7:0]};
      3'd1:    bus.dataR = {{16{rd_word[15]}}, rd_word[15:0]};
      3'd4:    bus.dataR = {24'h0, rd_word[7:0]};
      3'd5:    bus.dataR = {16'h0, rd_word[15:0]};
      default: bus.dataR = mem[bus.addr[7:2]];
    endcase
  end
  always @(posedge clk) begin
    if (bus.mem_write) begin
      case (bus.func3[1:0])
        2'd0:    mem[bus.addr[7:2]][{bus.addr[1:0], 3'b000} +: 8] = bus.dataW[7:0];
        2'd1:    mem[bus.addr[7:2]][{bus.addr[1], 4'b0000} +: 16] = bus.dataW[15:0];
        default: mem[bus.addr[7:2]] = bus.dataW;
      endcase
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // scoreboard: every rvalid must match the oldest expected load in port, data and cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cpu_rvalid || bus.dbg_rvalid) begin
        if (sb.size() == 0) chk("unexpected_rvalid", {62'h0, bus.cpu_rvalid, bus.dbg_rvalid}, 64'h0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("rvalid_port", {62'h0, bus.cpu_rvalid, bus.dbg_rvalid}, e.dbg ? 64'h1 : 64'h2);
          chk("rdata", e.dbg ? {32'h0, bus.dbg_rdata} : {32'h0, bus.cpu_rdata}, {32'h0, e.data});
          chk("rvalid_latency", 64'(cyc), 64'(e.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk("missing_rvalid", 64'h0, 64'h1);
        void'(sb.pop_front());
      end
    end
  end
  task automatic set_cpu(input logic req, input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ex);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_opcode = we ? 7'd35 : 7'd3;
    bus.cpu_func3 = f3; bus.cpu_addr = a; bus.cpu_wdata = wd; cpu_exp = ex;
  endtask
  task automatic set_dbg(input logic req, input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ex);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_func3 = f3;
    bus.dbg_addr = a; bus.dbg_wdata = wd; dbg_exp = ex;
  endtask
  task automatic tick();
    #1;
    g_cpu = bus.cpu_gnt; g_dbg = bus.dbg_gnt; g_stall = bus.cpu_stall;
    if (g_cpu && bus.cpu_req && !bus.cpu_we) sb.push_back('{1'b0, cpu_exp, cyc + 2});
    if (g_dbg && bus.dbg_req && !bus.dbg_we) sb.push_back('{1'b1, dbg_exp, cyc + 2});
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h8433_2211;
    mem[1] = 32'h0055_AA77;
    rst = 1'b1;
`ifdef DMEM_ARB_LOCK_EN
    dbg_lock = 1'b0;
`endif
    // reset with random fields and both requests raised
    for (int i = 0; i < 3; i++) begin
      set_cpu(1'b1, 1'($urandom), 3'($urandom), $urandom, $urandom, 32'h0);
      set_dbg(1'b1, 1'($urandom), 3'($urandom), $urandom, $urandom, 32'h0);
      #1;
      chk("rst_gnt", {62'h0, bus.cpu_gnt, bus.dbg_gnt}, 64'h0);
      chk("rst_stall", 64'(bus.cpu_stall), 64'h0);
      chk("rst_strobes", {62'h0, bus.mem_read, bus.mem_write}, 64'h0);
      chk("rst_fields", {bus.opcode, bus.func3, bus.addr}, 64'h0);
      chk("rst_dataW", 64'(bus.dataW), 64'h0);
      chk("rst_rdata", {bus.cpu_rdata, bus.dbg_rdata}, 64'h0);
      chk("rst_rvalid", {62'h0, bus.cpu_rvalid, bus.dbg_rvalid}, 64'h0);
      @(negedge clk);
    end
    rst = 1'b0;
    set_cpu(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0);
    set_dbg(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_strobes", {62'h0, bus.mem_read, bus.mem_write}, 64'h0);
    end
    // CPU LB from byte 3 of word 0
    set_cpu(1'b1, 1'b0, 3'd0, 32'd3, 32'h0, 32'hFFFF_FF84);
    tick();
    chk("lb_gnt", {62'h0, g_cpu, g_stall}, 64'h2);
    set_cpu(1'b0, 1'b0, 3'd0, 32'd3, 32'h0, 32'h0);
    chk("lb_bus_strobes", {62'h0, bus.mem_read, bus.mem_write}, 64'h2);
    chk("lb_bus_fields", {bus.opcode, bus.func3, bus.addr}, {7'd3, 3'd0, 32'd3});
    tick();
    tick();
    chk("lb_rvalid_pulse", 64'(bus.cpu_rvalid), 64'h0);
    chk("lb_rdata_hold", 64'(bus.cpu_rdata), 64'hFFFF_FF84);
    // fairness with both requests held: four CPU grants then one DBG grant, no idle cycles
    set_cpu(1'b1, 1'b0, 3'd2, 32'd0, 32'h0, 32'h8433_2211);
    set_dbg(1'b1, 1'b0, 3'd2, 32'd4, 32'h0, 32'h0055_AA77);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("fair_gnt", {62'h0, g_cpu, g_dbg}, (i % 5 == 4) ? 64'h1 : 64'h2);
      chk("fair_stall", 64'(g_stall), (i % 5 == 4) ? 64'h1 : 64'h0);
    end
    set_cpu(1'b0, 1'b0, 3'd2, 32'd0, 32'h0, 32'h0);
    set_dbg(1'b0, 1'b0, 3'd2, 32'd4, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    // cross-port coherence: DBG SW then CPU LW of the same word, then DBG LH
    set_dbg(1'b1, 1'b1, 3'd2, 32'd8, 32'hDEAD_BEEF, 32'h0);
    tick();
    chk("dsw_gnt", 64'(g_dbg), 64'h1);
    chk("dsw_bus_strobes", {62'h0, bus.mem_read, bus.mem_write}, 64'h1);
    chk("dsw_bus_fields", {bus.opcode, bus.func3, bus.addr}, {7'd35, 3'd2, 32'd8});
    chk("dsw_dataW", 64'(bus.dataW), 64'hDEAD_BEEF);
    set_dbg(1'b0, 1'b0, 3'd2, 32'd8, 32'h0, 32'h0);
    set_cpu(1'b1, 1'b0, 3'd2, 32'd8, 32'h0, 32'hDEAD_BEEF);
    tick();
    chk("clw_gnt", 64'(g_cpu), 64'h1);
    chk("clw_bus_read", {62'h0, bus.mem_read, bus.mem_write}, 64'h2);
    set_cpu(1'b0, 1'b0, 3'd2, 32'd8, 32'h0, 32'h0);
    set_dbg(1'b1, 1'b0, 3'd1, 32'd10, 32'h0, 32'hFFFF_DEAD);
    tick();
    chk("dlh_gnt", 64'(g_dbg), 64'h1);
    chk("dlh_opcode", 64'(bus.opcode), 64'd3);
    set_dbg(1'b0, 1'b0, 3'd1, 32'd10, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    chk("coh_cpu_rdata", 64'(bus.cpu_rdata), 64'hDEAD_BEEF);
    chk("coh_dbg_rdata", 64'(bus.dbg_rdata), 64'hFFFF_DEAD);
    // reset while a CPU store is on the bus, with the starvation counter non-zero
    set_cpu(1'b1, 1'b0, 3'd2, 32'd0, 32'h0, 32'h8433_2211);
    set_dbg(1'b1, 1'b0, 3'd2, 32'd4, 32'h0, 32'h0055_AA77);
    tick();
    tick();
    chk("pre_rst_gnt", {62'h0, g_cpu, g_dbg}, 64'h2);
    set_cpu(1'b1, 1'b1, 3'd2, 32'd12, 32'h1234_5678, 32'h0);
    tick();
    chk("sw_gnt", 64'(g_cpu), 64'h1);
    set_cpu(1'b0, 1'b0, 3'd2, 32'd12, 32'h0, 32'h0);
    set_dbg(1'b0, 1'b0, 3'd2, 32'd4, 32'h0, 32'h0);
    chk("sw_bus_write", {62'h0, bus.mem_read, bus.mem_write}, 64'h1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_strobes", {62'h0, bus.mem_read, bus.mem_write}, 64'h0);
    chk("mid_rst_addr", 64'(bus.addr), 64'h0);
    chk("mid_rst_rdata", 64'(bus.cpu_rdata), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_strobes", {62'h0, bus.mem_read, bus.mem_write}, 64'h0);
    chk("post_rst_mem", 64'(mem[3]), 64'h0);
    set_cpu(1'b1, 1'b0, 3'd2, 32'd0, 32'h0, 32'h8433_2211);
    set_dbg(1'b1, 1'b0, 3'd2, 32'd4, 32'h0, 32'h0055_AA77);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_fair", {62'h0, g_cpu, g_dbg}, (i == 4) ? 64'h1 : 64'h2);
    end
`ifdef DMEM_ARB_LOCK_EN
    // DBG lock: CPU fully stalled while locked, regains priority once released
    dbg_lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("lock_gnt", {62'h0, g_cpu, g_dbg}, 64'h1);
      chk("lock_stall", 64'(g_stall), 64'h1);
    end
    dbg_lock = 1'b0;
    tick();
    chk("unlock_gnt", {62'h0, g_cpu, g_dbg}, 64'h2);
`endif
    set_cpu(1'b0, 1'b0, 3'd2, 32'd0, 32'h0, 32'h0);
    set_dbg(1'b0, 1'b0, 3'd2, 32'd4, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
